// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Saturating 32-bit add used by the performance counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch_fifo
//  Description : Synchronous FIFO with flush; head is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;

    // Extra pointer bit distinguishes full from empty.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign head_data = (count == '0) ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch_unit
//  Description : Credit-limited instruction fetch with prefetch FIFO and flush.
//                Optional FETCH_PERF_EN adds saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit #(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flushed,
`endif
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    import riscv_pkg::*;

    localparam int unsigned c_cw = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_cw-1:0]    r_discard;
    logic [c_cw-1:0]    w_tag_count;
    logic [c_cw-1:0]    w_fifo_count;
    logic [c_cw-1:0]    w_outstanding;
    logic [c_cw:0]      w_inflight;
    logic [XLEN-1:0]    w_tag_pc;
    logic [2*XLEN-1:0]  w_head;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_req_fire;
    logic               w_rsp_take;
    logic               w_pop;

    // Requests whose tags were flushed are exactly the ones still to be discarded.
    assign w_outstanding  = w_tag_count + r_discard;
    assign w_inflight     = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = (r_state == S_RUN) && (w_inflight < (c_cw+1)'(FIFO_DEPTH))
                            && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_take     = imem_rsp_valid && (r_discard == '0);
    assign w_redirect_pc  = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

    assign if_valid = (w_fifo_count != '0);
    assign if_pc    = w_head[2*XLEN-1:XLEN];
    assign if_instr = w_head[XLEN-1:0];
    assign w_pop    = if_valid && if_ready;

    riscv_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (w_req_fire),
        .push_data (r_fetch_pc),
        .pop       (w_rsp_take),
        .head_data (w_tag_pc),
        .count     (w_tag_count)
    );

    riscv_fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_entry_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (w_rsp_take && !redirect_valid),
        .push_data ({w_tag_pc, imem_rsp_data}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_BOOT;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:  w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_discard  <= w_outstanding - {{(c_cw-1){1'b0}}, imem_rsp_valid};
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - c_cw'(1);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_inc;

    always_comb begin
        w_flush_inc = '0;
        if (redirect_valid)
            w_flush_inc = 32'(w_fifo_count) - 32'(w_pop) + 32'(imem_rsp_valid);
        else if (imem_rsp_valid && (r_discard != '0))
            w_flush_inc = 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_pop));
            r_perf_stall   <= sat_add(r_perf_stall,
                                      32'(if_ready && !if_valid && (r_state == S_RUN)));
            r_perf_flushed <= sat_add(r_perf_flushed, w_flush_inc);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_fetch_unit
//  Description : Self-checking bench: in-order memory model plus fetch reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flushed;
`endif

    riscv_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flushed   (perf_flushed),
`endif
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: pending memory requests (tagged by redirect epoch),
    // instructions waiting for decode, and the next address fetch should use.
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] target; logic [31:0] a0; logic [31:0] a1; logic [31:0] a2; } redir_vec_t;

    req_t        req_q[$];
    ent_t        mfifo[$];
    logic [31:0] dlv_q[$];
    logic [31:0] fire_q[$];
    logic [31:0] fetch_exp;
    int          total, bad, cyc, epoch, last_due, lat_min, lat_max;
    logic        last_req_valid, last_if_valid;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0135_7913;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic rsp_now();
        return (req_q.size() > 0) && (req_q[0].due <= cyc);
    endfunction

    task automatic run_cycle(input logic redir, input logic [31:0] rpc,
                             input logic rdy, input logic mrdy);
        logic rsp, exp_rv, fire, pop;
        req_t r;
        ent_t e;
        int   lat;
        @(negedge clk);
        rsp            = rsp_now();
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(req_q[0].addr) : $urandom;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_req_ready = mrdy;
        #1;
        exp_rv = ((req_q.size() + mfifo.size()) < DEPTH) && !redir;
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        check("req_addr", imem_req_addr, fetch_exp);
        check("if_valid", {31'd0, if_valid}, {31'd0, mfifo.size() != 0});
        if (mfifo.size() != 0) begin
            check("if_pc", if_pc, mfifo[0].pc);
            check("if_instr", if_instr, mfifo[0].instr);
        end
        last_req_valid = imem_req_valid;
        last_if_valid  = if_valid;
        // Advance the model across the coming rising edge.
        pop  = (mfifo.size() != 0) && rdy;
        fire = exp_rv && mrdy;
        if (pop) begin
            dlv_q.push_back(mfifo[0].pc);
            void'(mfifo.pop_front());
        end
        if (rsp) begin
            r = req_q.pop_front();
            if (!redir && r.epoch == epoch) begin
                e.pc    = r.addr;
                e.instr = instr_of(r.addr);
                mfifo.push_back(e);
            end
        end
        if (redir) begin
            mfifo.delete();
            epoch++;
            fetch_exp = rpc & 32'hFFFF_FFFC;
        end else if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            r.addr  = fetch_exp;
            r.epoch = epoch;
            r.due   = (cyc + lat <= last_due) ? last_due + 1 : cyc + lat;
            last_due = r.due;
            req_q.push_back(r);
            fire_q.push_back(fetch_exp);
            fetch_exp = fetch_exp + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        req_q.delete();
        mfifo.delete();
        dlv_q.delete();
        fire_q.delete();
        fetch_exp = RESET_PC;
        last_due  = cyc;
        #1;
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
        check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("boot_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_deliveries(input int n, input string name);
        int guard;
        guard = 0;
        while (dlv_q.size() < n && guard < 100) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
            guard++;
        end
        if (dlv_q.size() < n) timeout(name);
    endtask

    redir_vec_t vecs[4];

    initial begin
        int guard, n0;
        total = 0; bad = 0; cyc = 0; epoch = 0; last_due = 0;
        lat_min = 1; lat_max = 1;
        reset_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        fetch_exp = RESET_PC;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vecs[3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};

        // Streaming with zero-wait memory
        do_reset();
        wait_deliveries(3, "t1_deliver");
        if (dlv_q.size() >= 3) begin
            check("t1_pc0", dlv_q[0], 32'h0);
            check("t1_pc1", dlv_q[1], 32'h4);
            check("t1_pc2", dlv_q[2], 32'h8);
        end

        // Decode stalled: credit limit caps outstanding work
        do_reset();
        repeat (20) run_cycle(1'b0, 32'd0, 1'b0, 1'b1);
        check("t2_fires", fire_q.size(), DEPTH);
        check("t2_req_valid_low", {31'd0, last_req_valid}, 32'd0);
        check("t2_if_valid", {31'd0, last_if_valid}, 32'd1);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        run_cycle(1'b0, 32'd0, 1'b0, 1'b1);
        check("t2_refill", fire_q.size(), DEPTH + 1);

        // Redirect with three requests in flight, 5-cycle latency
        lat_min = 5; lat_max = 5;
        do_reset();
        guard = 0;
        while (req_q.size() < 3 && guard < 20) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
            guard++;
        end
        if (req_q.size() < 3) timeout("t3_outstanding");
        check("t3_outstanding", req_q.size(), 3);
        n0 = fire_q.size();
        dlv_q.delete();
        run_cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        wait_deliveries(1, "t3_deliver");
        if (dlv_q.size() >= 1) check("t3_first_pc", dlv_q[0], 32'h0000_0100);
        if (fire_q.size() > n0) check("t3_first_req", fire_q[n0], 32'h0000_0100);

        // Redirect coinciding with a response, then a second redirect
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (3) run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
        guard = 0;
        while (!rsp_now() && guard < 20) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
            guard++;
        end
        if (!rsp_now()) timeout("t4_rsp_align");
        run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        n0 = fire_q.size();
        dlv_q.delete();
        run_cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        wait_deliveries(1, "t4_deliver");
        if (dlv_q.size() >= 1) check("t4_first_pc", dlv_q[0], 32'h0000_0300);
        if (fire_q.size() > n0) check("t4_first_req", fire_q[n0], 32'h0000_0300);

        // Table of redirect targets, including address wrap
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n0 = fire_q.size();
            run_cycle(1'b1, vecs[i].target, 1'b1, 1'b1);
            guard = 0;
            while (fire_q.size() < n0 + 3 && guard < 30) begin
                run_cycle(1'b0, 32'd0, 1'b1, 1'b1);
                guard++;
            end
            if (fire_q.size() < n0 + 3) timeout("tv_fires");
            else begin
                check("tv_a0", fire_q[n0],     vecs[i].a0);
                check("tv_a1", fire_q[n0 + 1], vecs[i].a1);
                check("tv_a2", fire_q[n0 + 2], vecs[i].a2);
            end
        end

        // Reset in the middle of a stream with a half-full FIFO
        do_reset();
        guard = 0;
        while (mfifo.size() < 2 && guard < 20) begin
            run_cycle(1'b0, 32'd0, 1'b0, 1'b1);
            guard++;
        end
        check("t6_half_full", mfifo.size(), 2);
        do_reset();
        wait_deliveries(1, "t6_deliver");
        if (dlv_q.size() >= 1) check("t6_restart_pc", dlv_q[0], RESET_PC);

        // Randomized traffic against the reference model
        lat_min = 1; lat_max = 6;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [31:0] tgt;
            rd  = ($urandom_range(99, 0) < 4);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            run_cycle(rd, tgt, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end
        check("rand_progress", {31'd0, dlv_q.size() > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
